// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: state encoding and divider math.
package uart_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP
  } uart_state_e;

  // Clock cycles per line bit (integer division, truncating).
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

  // Width of a counter that must hold 0..div-1; never narrower than one bit.
  function automatic int cnt_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period timer: counts 0..DIV-1 while enabled, flags the last and
// second-to-last cycle of each bit, and restarts from zero on clr.
module uart_baud_cnt
  import uart_pkg::*;
#(
  parameter int DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic bit_end,
  output logic pre_end
);

  localparam int W = cnt_width(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  localparam logic [W-1:0] PRE  = W'(DIV - 2);

  logic [W-1:0] cnt;

  // Free-running within a bit, wraps to zero on each bit boundary.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      cnt <= '0;
    else if (clr)    cnt <= '0;
    else if (en)     cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
  end

  assign bit_end = en && !clr && (cnt == LAST);
  assign pre_end = en && !clr && (cnt == PRE);

endmodule

// File: rtl/uart_tx_serializer.sv
// UART transmitter: valid/ready byte intake into a one-byte holding register,
// framed as start / data LSB-first / optional parity / stop bits.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       frame_done
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD);
  localparam logic [2:0] DATA_LAST = 3'(DATA_BITS - 1);
  localparam logic [2:0] STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [7:0] DATA_MASK = 8'((1 << DATA_BITS) - 1);

  if (DIV < 2) begin : g_bad_div
    $error("uart_tx_serializer: CLK_FREQ/BAUD must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_bad_data_bits
    $error("uart_tx_serializer: DATA_BITS must be 5..8");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx_serializer: STOP_BITS must be 1 or 2");
  end

  uart_state_e state, state_nxt;
  logic [7:0]  hold, shift, shift_nxt;
  logic        hold_full, hold_full_nxt;
  logic [2:0]  bit_cnt, bit_cnt_nxt;
  logic        par, par_nxt;
  logic        tx_nxt, done_nxt;
  logic        load, accept;
  logic        bit_end, pre_end;

  // Ready is a registered copy of !hold_full, so this has no path from valid to ready.
  assign accept = data_in_valid && data_in_ready;

  // Counter is parked at zero in IDLE so START always gets a full DIV cycles.
  uart_baud_cnt #(.DIV(DIV)) u_baud (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (state != IDLE),
    .clr     (state == IDLE),
    .bit_end (bit_end),
    .pre_end (pre_end)
  );

  // Next-state, datapath and next-output decode; outputs are registered below.
  always_comb begin
    state_nxt   = state;
    shift_nxt   = shift;
    bit_cnt_nxt = bit_cnt;
    par_nxt     = par;
    load        = 1'b0;
    done_nxt    = 1'b0;
    tx_nxt      = 1'b1;

    case (state)
      IDLE: if (hold_full) load = 1'b1;
      START: if (bit_end) begin
        state_nxt   = DATA;
        bit_cnt_nxt = '0;
      end
      DATA: if (bit_end) begin
        if (bit_cnt == DATA_LAST) begin
          state_nxt   = (PARITY_EN != 0) ? PARITY : STOP;
          bit_cnt_nxt = '0;
        end else begin
          bit_cnt_nxt = bit_cnt + 1'b1;
          shift_nxt   = {1'b0, shift[7:1]};
        end
      end
      PARITY: if (bit_end) begin
        state_nxt   = STOP;
        bit_cnt_nxt = '0;
      end
      STOP: begin
        // Registered pulse: raise it one cycle early so it lands on the final cycle.
        if (bit_cnt == STOP_LAST && pre_end) done_nxt = 1'b1;
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            if (hold_full) load = 1'b1;
            else           state_nxt = IDLE;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Loading a new byte frees the holding register and starts a frame.
    if (load) begin
      state_nxt   = START;
      shift_nxt   = hold & DATA_MASK;
      par_nxt     = (^(hold & DATA_MASK)) ^ 1'(PARITY_ODD);
      bit_cnt_nxt = '0;
    end

    hold_full_nxt = load ? 1'b0 : (accept ? 1'b1 : hold_full);

    case (state_nxt)
      START:   tx_nxt = 1'b0;
      DATA:    tx_nxt = shift_nxt[0];
      PARITY:  tx_nxt = par_nxt;
      default: tx_nxt = 1'b1;
    endcase
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      shift         <= '0;
      hold          <= '0;
      hold_full     <= 1'b0;
      bit_cnt       <= '0;
      par           <= 1'b0;
      tx            <= 1'b1;
      tx_busy       <= 1'b0;
      frame_done    <= 1'b0;
      data_in_ready <= 1'b1;
    end else begin
      state         <= state_nxt;
      shift         <= shift_nxt;
      hold_full     <= hold_full_nxt;
      bit_cnt       <= bit_cnt_nxt;
      par           <= par_nxt;
      tx            <= tx_nxt;
      tx_busy       <= (state_nxt != IDLE);
      frame_done    <= done_nxt;
      data_in_ready <= !hold_full_nxt;
      if (accept) hold <= data_in;
    end
  end

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Bench for uart_tx_serializer: four configurations (8N1, 8E1, 8O1, 7N2) at DIV=10,
// table-driven frames plus back-to-back, mid-frame reset and valid-toggle sequences.
module tb_uart_tx_serializer;

  localparam int DIV = 10;

  typedef struct {
    int         inst;
    logic [7:0] data;
    int         len;
    int         par;   // -1: no parity bit
  } vec_t;

  typedef struct {
    logic [7:0] data;
    int         len;
    int         par;
    bit         abort;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic [3:0] vld, rdy, txl, busy, done;

  int   nvec = 0;
  int   nerr = 0;
  int   cyc  = 0;
  exp_t sb[4][$];
  int   fstart[4][$];
  int   NB[4] = '{8, 8, 8, 7};

  uart_tx_serializer #(.CLK_FREQ(50_000_000), .BAUD(5_000_000)) u0 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(vld[0]),
    .data_in_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]), .frame_done(done[0]));
  uart_tx_serializer #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(vld[1]),
    .data_in_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]), .frame_done(done[1]));
  uart_tx_serializer #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(vld[2]),
    .data_in_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]), .frame_done(done[2]));
  uart_tx_serializer #(.CLK_FREQ(50_000_000), .BAUD(5_000_000), .DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst_n(rst_n), .data_in(din), .data_in_valid(vld[3]),
    .data_in_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]), .frame_done(done[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    nvec++;
    if (act !== req) begin
      nerr++;
      $display("FAIL %s: got %0d, want %0d", name, act, req);
    end
  endtask

  // Frame monitor: pops the expected frame at each start bit and checks it cycle by cycle.
  task automatic mon(input int k);
    exp_t e;
    int   first_bad, bad_fd, bad_busy, b;
    bit   aborted, have;
    logic exp_b;
    have = 1'b0;
    forever begin
      if (!have) @(negedge clk);
      have = 1'b0;
      if (rst_n === 1'b1 && txl[k] === 1'b0) begin
        if (sb[k].size() == 0) begin
          chk($sformatf("unexpected_frame_u%0d", k), 1, 0);
          while (txl[k] === 1'b0 && rst_n === 1'b1) @(negedge clk);
        end else begin
          e = sb[k].pop_front();
          fstart[k].push_back(cyc);
          chk($sformatf("ready_at_load_u%0d", k), rdy[k], 1);
          first_bad = -1; bad_fd = 0; bad_busy = 0; aborted = 1'b0;
          for (int i = 0; i < e.len; i++) begin
            if (i > 0) @(negedge clk);
            if (rst_n !== 1'b1) begin aborted = 1'b1; break; end
            b = i / DIV;
            if (b == 0)                            exp_b = 1'b0;
            else if (b <= NB[k])                   exp_b = e.data[b-1];
            else if (b == NB[k] + 1 && e.par >= 0) exp_b = e.par[0];
            else                                   exp_b = 1'b1;
            if (txl[k] !== exp_b && first_bad < 0) first_bad = i;
            if (done[k] !== (i == e.len - 1)) bad_fd++;
            if (busy[k] !== 1'b1) bad_busy++;
          end
          if (e.abort) begin
            chk($sformatf("abort_seen_u%0d", k), aborted, 1);
          end else begin
            chk($sformatf("frame_complete_u%0d_%02h", k, e.data), aborted, 0);
            chk($sformatf("tx_first_bad_cycle_u%0d_%02h", k, e.data), first_bad, -1);
            chk($sformatf("frame_done_bad_cycles_u%0d_%02h", k, e.data), bad_fd, 0);
            chk($sformatf("busy_low_cycles_u%0d_%02h", k, e.data), bad_busy, 0);
            @(negedge clk);
            have = 1'b1;
            if (sb[k].size() == 0 && rst_n === 1'b1) begin
              chk($sformatf("busy_after_u%0d", k), busy[k], 0);
              chk($sformatf("done_after_u%0d", k), done[k], 0);
            end
          end
        end
      end
    end
  endtask

  for (genvar g = 0; g < 4; g++) begin : g_mon
    initial mon(g);
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input int k, input logic [7:0] d, input int len, input int par,
                      input bit abort, input bit keep);
    int n;
    n = 0;
    din = d;
    vld[k] = 1'b1;
    while (rdy[k] !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    if (n >= 2000) begin
      chk($sformatf("accept_timeout_u%0d", k), 0, 1);
      vld[k] = 1'b0;
      return;
    end
    @(posedge clk);
    sb[k].push_back('{data: d, len: len, par: par, abort: abort});
    @(negedge clk);
    chk($sformatf("ready_drop_u%0d", k), rdy[k], 0);
    if (!keep) vld[k] = 1'b0;
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    while ((sb[k].size() != 0 || busy[k] !== 1'b0) && n < 3000) begin @(negedge clk); n++; end
    chk($sformatf("idle_timeout_u%0d", k), (n < 3000), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    vec_t tbl[10];
    int   g1, g2, cap, lowc;
    tbl[0] = '{inst: 0, data: 8'h55, len: 100, par: -1};
    tbl[1] = '{inst: 0, data: 8'h00, len: 100, par: -1};
    tbl[2] = '{inst: 0, data: 8'hFF, len: 100, par: -1};
    tbl[3] = '{inst: 1, data: 8'h07, len: 110, par: 1};
    tbl[4] = '{inst: 2, data: 8'h07, len: 110, par: 0};
    tbl[5] = '{inst: 1, data: 8'hA5, len: 110, par: 0};
    tbl[6] = '{inst: 2, data: 8'h00, len: 110, par: 1};
    tbl[7] = '{inst: 3, data: 8'h80, len: 100, par: -1};
    tbl[8] = '{inst: 3, data: 8'h2B, len: 100, par: -1};
    tbl[9] = '{inst: 1, data: 8'hC1, len: 110, par: 1};

    vld = '0;
    din = '0;
    rst_n = 1'b1;
    #3 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_tx", txl, 4'hF);
    chk("rst_busy", busy, 4'h0);
    chk("rst_ready", rdy, 4'hF);
    chk("rst_done", done, 4'h0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 10; v++) begin
      send(tbl[v].inst, tbl[v].data, tbl[v].len, tbl[v].par, 1'b0, 1'b0);
      wait_idle(tbl[v].inst);
    end

    // Back-to-back frames with valid held high: no idle bit between them.
    fstart[0].delete();
    send(0, 8'hA5, 100, -1, 1'b0, 1'b1);
    send(0, 8'h3C, 100, -1, 1'b0, 1'b1);
    send(0, 8'hFF, 100, -1, 1'b0, 1'b0);
    wait_idle(0);
    chk("b2b_frame_count", fstart[0].size(), 3);
    g1 = (fstart[0].size() >= 3) ? fstart[0][1] - fstart[0][0] : -1;
    g2 = (fstart[0].size() >= 3) ? fstart[0][2] - fstart[0][1] : -1;
    chk("b2b_gap1", g1, 100);
    chk("b2b_gap2", g2, 100);

    // Reset in the middle of a frame aborts it immediately.
    send(0, 8'h00, 100, -1, 1'b1, 1'b0);
    repeat (45) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_tx", txl[0], 1);
    chk("midrst_busy", busy[0], 0);
    chk("midrst_ready", rdy[0], 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    lowc = 0;
    repeat (30) begin
      @(negedge clk);
      if (txl[0] !== 1'b1 || busy[0] !== 1'b0) lowc++;
    end
    chk("post_rst_idle", lowc, 0);
    send(0, 8'h81, 100, -1, 1'b0, 1'b0);
    wait_idle(0);

    // Valid toggling with junk data while the holding register is full.
    send(0, 8'h3C, 100, -1, 1'b0, 1'b0);
    send(0, 8'hC3, 100, -1, 1'b0, 1'b0);
    cap = 0;
    for (int j = 0; j < 40; j++) begin
      din = 8'($urandom);
      vld[0] = j[0];
      @(negedge clk);
      if (rdy[0] !== 1'b0) cap++;
    end
    vld[0] = 1'b0;
    chk("toggle_ready_stayed_low", cap, 0);
    wait_idle(0);

    chk("scoreboard_empty", sb[0].size() + sb[1].size() + sb[2].size() + sb[3].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
